// File: rtl/reg_file_2r1w.sv
// 2**ADDR_W x DATA_W register file: two combinational read ports, one write port taking effect on the rising edge, r0 hardwired to zero.
// Write latency 1 cycle; reads 0 cycles, with optional write-through bypass; no handshake, a write is accepted every cycle.
module reg_file_2r1w #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr_en;

    // Entry 0 is cleared by reset and never written; reads of 0 are forced below anyway.
    assign wr_en = RegWrite && (WriteRegister != '0);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[WriteRegister] <= WriteData;
        end
    end

    logic bypass_en;
    logic hit1;
    logic hit2;

    // Reset suppresses the bypass so a discarded write is never visible.
    assign bypass_en = BYPASS && RegWrite && !Reset;
    assign hit1      = bypass_en && (WriteRegister == ReadRegister1);
    assign hit2      = bypass_en && (WriteRegister == ReadRegister2);

    always_comb begin
        ReadData1 = regs[ReadRegister1];
        if (ReadRegister1 == '0) begin
            ReadData1 = '0;
        end else if (hit1) begin
            ReadData1 = WriteData;
        end
    end

    always_comb begin
        ReadData2 = regs[ReadRegister2];
        if (ReadRegister2 == '0) begin
            ReadData2 = '0;
        end else if (hit2) begin
            ReadData2 = WriteData;
        end
    end

endmodule

// File: doc/reg_file_2r1w.md
# reg_file_2r1w

32 x 32-bit general-purpose register file with two asynchronous read ports and one synchronous write port. It is the consumer of the 5-bit write-destination select produced in the decode/write-back path: the selected register number (rt or rd) arrives on `WriteRegister`, and the write-back value arrives on `WriteData`. Register 0 is hardwired to zero. An optional write-through bypass lets same-cycle reads see the value being written.

## Interface

Parameters:
- `DATA_W`, 32, width of each register and of the data ports.
- `ADDR_W`, 5, register-number width; depth is 2**ADDR_W.
- `BYPASS`, 1, 1 = a read of the register being written this cycle returns `WriteData`; 0 = the read returns the old contents.

Ports:
- `Clk`  input  1  system clock; all state changes on the rising edge.
- `Reset`  input  1  synchronous, active-high; clears all registers on the next rising edge.
- `RegWrite`  input  1  write enable for the current cycle.
- `WriteRegister`  input  ADDR_W  destination register number (output of the 5-bit 2:1 destination mux).
- `WriteData`  input  DATA_W  value to write.
- `ReadRegister1`  input  ADDR_W  read port 1 address (rs).
- `ReadRegister2`  input  ADDR_W  read port 2 address (rt).
- `ReadData1`  output  DATA_W  contents of `ReadRegister1`.
- `ReadData2`  output  DATA_W  contents of `ReadRegister2`.

## Operation

- Storage: 2**ADDR_W registers of DATA_W bits. Entry 0 is never written; it reads as 0 at all times.
- Write: on a rising `Clk` with `Reset`=0, `RegWrite`=1 and `WriteRegister`!=0, register[`WriteRegister`] <= `WriteData`. A write with `WriteRegister`=0 is silently dropped.
- Reset: on a rising `Clk` with `Reset`=1, every register <= 0. Reset dominates: a concurrent write is discarded. `Reset` asserted for several cycles keeps all registers at 0. After reset deasserts, the first edge with `RegWrite`=1 writes normally.
- Read: `ReadDataN` is combinational from the address and storage, with no clock latency.
  - `ReadRegisterN`=0 -> 0, regardless of `BYPASS` or any write to 0.
  - `BYPASS`=1, `RegWrite`=1, `Reset`=0, `WriteRegister`=`ReadRegisterN`!=0 -> `ReadDataN`=`WriteData` in the same cycle.
  - Otherwise -> register[`ReadRegisterN`].
- Both read ports are independent and may address the same register. Either or both may match the write address at the same time; the bypass rule applies to each port separately.
- No X propagation: every storage bit is defined after the first reset edge. Before the first reset, contents are unspecified, except that reads of register 0 still return 0.

## Timing

- Write latency: 1 cycle. A value written at edge N is visible on a read port after edge N, with no bypass needed.
- Bypass path: `WriteData` -> `ReadDataN` is combinational. It must close timing in the same cycle as the ALU path.
- Reset values: all registers are 0. `ReadData1` and `ReadData2` are 0 for any address from the cycle after the reset edge until the first write.
- No handshakes and no stall input: a write is accepted every cycle.

## Test plan

- Reset clear: write 0xDEADBEEF to r5, then assert `Reset` for 1 cycle. Then `ReadRegister1`=5 -> `ReadData1`=0x00000000.
- Basic write/read: write 0x12345678 to r31 and 0xCAFEF00D to r1 on consecutive edges. Then read r31 on port 1 and r1 on port 2 -> 0x12345678 and 0xCAFEF00D.
- r0 immutable: `RegWrite`=1, `WriteRegister`=0, `WriteData`=0xFFFFFFFF, with both read ports on 0 -> both outputs 0 during the cycle and after the edge.
- Bypass: r7 holds 0x00000011. In one cycle, write 0x00000022 to r7 with both read ports on 7. With `BYPASS`=1 -> 0x00000022 on both before the edge. With `BYPASS`=0 -> 0x00000011 before the edge and 0x00000022 after.
- Reset vs. write collision: `Reset`=1 and `RegWrite`=1, `WriteRegister`=9, `WriteData`=0xA5A5A5A5 on the same edge. After the edge, read r9 -> 0. The bypass output during that cycle must not show 0xA5A5A5A5.
- Sweep: write register i <= i*0x01010101 for i=1..31, then read all pairs (i, 31-i) -> the stored values, with the r0 entry reading 0.
